// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches, buffers returned words with their PCs,
// and discards in-flight results after a redirect.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic [1:0]  dbg_state
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      STALE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   buf_instr [DEPTH];
   logic [31:0]   buf_pc    [DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q, count_after;
   logic [31:0]   target_pc;
   logic          push, pop, has_room;
   logic          unused_pc_bits;

   assign target_pc      = {redirect_pc_i[31:2], 2'b00};
   assign unused_pc_bits = ^redirect_pc_i[1:0];

   // Handshakes: a memory transfer is mem_req_o & mem_ack_i (acks without a request
   // are ignored); a decode transfer is instr_valid_o & instr_ready_i and pops the head.
   assign mem_req_o     = (state_q == WAIT) || (state_q == STALE);
   assign mem_addr_o    = addr_q;
   assign instr_valid_o = (count_q != '0);
   assign dbg_state     = state_q;

   assign push = (state_q == WAIT) && mem_ack_i && !redirect_i;
   assign pop  = instr_valid_o && instr_ready_i;

   // Credit: a new request only goes out if the word it returns is guaranteed a slot.
   assign count_after = count_q + CW'(push) - CW'(pop);
   assign has_room    = redirect_i || (count_after < CW'(DEPTH));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      fetch_pc_d = fetch_pc_q;
      if (redirect_i) begin
         fetch_pc_d = target_pc;
      end
      case (state_q)
         IDLE: begin
            if (redirect_i) begin
               state_d = WAIT;
               addr_d  = target_pc;
            end else if (has_room) begin
               state_d = WAIT;
               addr_d  = fetch_pc_q;
            end
         end
         WAIT: begin
            if (mem_ack_i) begin
               if (redirect_i) begin
                  state_d = WAIT;
                  addr_d  = target_pc;
               end else begin
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  if (has_room) begin
                     state_d = WAIT;
                     addr_d  = fetch_pc_q + 32'd4;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else if (redirect_i) begin
               state_d = STALE;
            end
         end
         STALE: begin
            // The returning word belongs to the old path; restart once it is gone.
            if (mem_ack_i) begin
               if (redirect_i) begin
                  state_d = WAIT;
                  addr_d  = target_pc;
               end else if (has_room) begin
                  state_d = WAIT;
                  addr_d  = fetch_pc_q;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC_ALIGNED;
         addr_q     <= RESET_PC_ALIGNED;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || redirect_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_after;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && push) begin
         buf_instr[wr_ptr_q] <= mem_rdata_i;
         buf_pc[wr_ptr_q]    <= addr_q;
      end
   end

   assign instr_o    = instr_valid_o ? buf_instr[rd_ptr_q] : 32'd0;
   assign pc_o       = instr_valid_o ? buf_pc[rd_ptr_q] : 32'd0;
   assign pc_plus4_o = instr_valid_o ? (buf_pc[rd_ptr_q] + 32'd4) : 32'd0;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, power of two >= 2, SHALL be the instruction-buffer entry count.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 mem_req_o  output  1  fetch request to instruction memory.
REQ-006 mem_addr_o  output  32  word-aligned fetch address.
REQ-007 mem_ack_i  input  1  memory has returned data for the current request.
REQ-008 mem_rdata_i  input  32  instruction word; valid only when mem_ack_i=1.
REQ-009 redirect_i  input  1  branch/jump taken; flush and restart fetch.
REQ-010 redirect_pc_i  input  32  restart address, sampled when redirect_i=1.
REQ-011 instr_valid_o  output  1  buffer head holds a valid instruction.
REQ-012 instr_ready_i  input  1  decode stage accepts the head this cycle.
REQ-013 instr_o  output  32  head instruction word.
REQ-014 pc_o  output  32  address of instr_o.
REQ-015 pc_plus4_o  output  32  pc_o+4, modulo 2^32.

Function
REQ-016 The block SHALL have the FSM states IDLE (no request), WAIT (request outstanding, result kept) and STALE (request outstanding, result to be discarded).
REQ-017 mem_req_o SHALL be 1 exactly in WAIT and STALE; mem_addr_o SHALL stay constant from assertion until the ack cycle.
REQ-018 A memory transfer SHALL occur on a cycle with mem_req_o=1 and mem_ack_i=1; mem_ack_i while mem_req_o=0 SHALL be ignored.
REQ-019 IDLE->WAIT SHALL occur, with mem_addr_o=fetch PC, when occupancy after this cycle's push/pop < DEPTH and no redirect.
REQ-020 On an ack in WAIT, {mem_rdata_i, mem_addr_o} SHALL be pushed, fetch PC SHALL advance by 4 (wrap at 2^32), and the next request SHALL be asserted in the next cycle if REQ-019 holds (back-to-back), else IDLE.
REQ-021 With zero-wait memory (ack in the request cycle) and instr_ready_i=1, throughput SHALL be one instruction per cycle.
REQ-022 Ack-to-instr_valid_o latency SHALL be one cycle (registered buffer, no bypass).
REQ-023 A decode transfer SHALL occur when instr_valid_o=1 and instr_ready_i=1 and SHALL pop the head.
REQ-024 instr_valid_o SHALL equal buffer non-empty; when empty, instr_o, pc_o and pc_plus4_o SHALL be 0.
REQ-025 On redirect_i=1, the buffer SHALL be emptied next cycle and fetch PC SHALL load {redirect_pc_i[31:2],2'b00}.
REQ-026 A redirect in WAIT with no ack in the same cycle SHALL move the FSM to STALE; its eventual ack data SHALL be dropped, and the next request (new PC) SHALL be asserted in the cycle after that ack.
REQ-027 A redirect in the ack cycle SHALL drop that data; the new PC SHALL be requested in the next cycle.
REQ-028 A redirect in IDLE SHALL request the new PC in the next cycle.
REQ-029 A redirect in STALE SHALL only update the fetch PC, remaining in STALE.
REQ-030 A decode transfer in a redirect cycle SHALL complete normally; push and pop in that cycle SHALL be discarded by the flush.
REQ-031 Simultaneous push and pop on a full buffer cannot occur (REQ-019 credit rule); simultaneous push and pop otherwise SHALL keep occupancy unchanged.

Reset
REQ-032 While rst_i=1, the FSM SHALL enter IDLE, the buffer SHALL empty, and fetch PC SHALL load RESET_PC; mem_req_o, instr_valid_o, instr_o, pc_o and pc_plus4_o SHALL be 0.
REQ-033 A reset mid-request SHALL abandon the request; mem_req_o SHALL be 0 from the cycle after rst_i is sampled high.
REQ-034 The first request SHALL assert in the first cycle after rst_i is sampled low, with mem_addr_o=RESET_PC.

Verification
REQ-035 Zero-wait memory, ready=1 -> pc_o sequence 0,4,8,12 on consecutive cycles, first valid 2 cycles after reset release.
REQ-036 ready=0, DEPTH=4, zero-wait memory -> exactly 4 acks, mem_req_o then 0, instr_valid_o=1 with pc_o=0; raise ready -> fetch resumes at 16.
REQ-037 Memory with 3-cycle ack; redirect_pc_i=32'h0000_0103 one cycle after request to 8 -> word from 8 dropped; next request addr 32'h0000_0100.
REQ-038 Redirect in the same cycle as an ack and a decode transfer -> instr_valid_o=0 next cycle; next request addr=redirect target.
REQ-039 rst_i pulsed while in WAIT at addr 32'h0000_0020 -> mem_req_o=0 next cycle, late ack ignored, next request addr=RESET_PC.
REQ-040 Fetch PC 32'hFFFF_FFFC, zero-wait memory -> pc_plus4_o=0, next request addr 0.
